// File: rtl/collision_monitor_if.sv
//------------------------------------------------------------------------------
// Module   : collision_monitor_if
// Brief    : Bus bundle between object-position logic and the collision monitor.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface collision_monitor_if #(
    parameter int W      = 10,
    parameter int N_OBST = 4,
    parameter int IDX_W  = 2
);
    logic                  frame_tick;
    logic                  start;
    logic [W-1:0]          dino_x;
    logic [W-1:0]          dino_y;
    logic [N_OBST*W-1:0]   obst_x;
    logic [N_OBST*W-1:0]   obst_y;
    logic [N_OBST-1:0]     obst_valid;
    logic [N_OBST-1:0]     hit_mask;
    logic                  hit_any;
    logic                  running;
    logic                  game_over;
    logic [IDX_W-1:0]      hit_idx;

    modport master (
        output frame_tick, start, dino_x, dino_y, obst_x, obst_y, obst_valid,
        input  hit_mask, hit_any, running, game_over, hit_idx
    );

    modport slave (
        input  frame_tick, start, dino_x, dino_y, obst_x, obst_y, obst_valid,
        output hit_mask, hit_any, running, game_over, hit_idx
    );
endinterface

`default_nettype wire

// File: rtl/collision_monitor.sv
//------------------------------------------------------------------------------
// Module   : collision_monitor
// Brief    : Multi-obstacle box-overlap check with persistence filter and
//            latched game over. Optional start-of-run grace: COLLIDE_GRACE_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module collision_monitor #(
    parameter int W            = 10,
    parameter int N_OBST       = 4,
    parameter int IDX_W        = 2,
    parameter int DINO_HW      = 20,
    parameter int DINO_HH      = 25,
    parameter int OBST_HW      = 10,
    parameter int OBST_HH      = 20,
    parameter int HIT_FRAMES   = 2,
    parameter int GRACE_FRAMES = 30
) (
    input  logic                  clk,
    input  logic                  restart,
    collision_monitor_if.slave    bus
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_OVER = 2'd2;

    localparam int             c_CNT_W      = $clog2(HIT_FRAMES) + 1;
    localparam logic [c_CNT_W-1:0] c_HIT_FRAMES = c_CNT_W'(HIT_FRAMES);
    localparam logic [W:0]     c_TH_X       = (W+1)'(DINO_HW + OBST_HW);
    localparam logic [W:0]     c_TH_Y       = (W+1)'(DINO_HH + OBST_HH);

    generate
        if (HIT_FRAMES < 1 || GRACE_FRAMES < 0 || N_OBST < 1 || N_OBST > 8 ||
            IDX_W < 1 || IDX_W < $clog2(N_OBST)) begin : g_param_check
            $error("collision_monitor: illegal parameter combination");
        end
    endgenerate

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [c_CNT_W-1:0]  r_hit_cnt;
    logic [c_CNT_W-1:0]  w_hit_cnt_nxt;
    logic [c_CNT_W-1:0]  w_hit_cnt_inc;
    logic [IDX_W-1:0]    r_hit_idx;
    logic [IDX_W-1:0]    w_hit_idx_nxt;
    logic [IDX_W-1:0]    w_low_idx;
    logic [N_OBST-1:0]   r_hit_mask;
    logic                r_hit_any;
    logic [N_OBST-1:0]   w_hit;
    logic                w_in_grace;

    // Per-channel overlap: |a-b| in W+1-bit signed so no coordinate pair wraps.
    generate
        for (genvar k = 0; k < N_OBST; k++) begin : g_chan
            logic signed [W:0] w_dx_s;
            logic signed [W:0] w_dy_s;
            logic [W:0]        w_adx;
            logic [W:0]        w_ady;

            assign w_dx_s   = $signed({1'b0, bus.dino_x}) - $signed({1'b0, bus.obst_x[k*W +: W]});
            assign w_dy_s   = $signed({1'b0, bus.dino_y}) - $signed({1'b0, bus.obst_y[k*W +: W]});
            assign w_adx    = (w_dx_s < 0) ? -w_dx_s : w_dx_s;
            assign w_ady    = (w_dy_s < 0) ? -w_dy_s : w_dy_s;
            assign w_hit[k] = bus.obst_valid[k] && (w_adx < c_TH_X) && (w_ady < c_TH_Y);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (restart) begin
            r_hit_mask <= '0;
            r_hit_any  <= 1'b0;
        end else begin
            r_hit_mask <= w_hit;
            r_hit_any  <= |w_hit;
        end
    end

    // Scan downward so the lowest set channel is the one left standing.
    always_comb begin
        w_low_idx = '0;
        for (int i = N_OBST - 1; i >= 0; i--) begin
            if (r_hit_mask[i]) begin
                w_low_idx = IDX_W'(i);
            end
        end
    end

    assign w_hit_cnt_inc = (r_hit_cnt == '1) ? r_hit_cnt : r_hit_cnt + 1'b1;

`ifdef COLLIDE_GRACE_EN
    localparam int c_GRACE_W = (GRACE_FRAMES > 0) ? $clog2(GRACE_FRAMES + 1) : 1;

    logic [c_GRACE_W-1:0] r_grace;
    logic [c_GRACE_W-1:0] w_grace_nxt;

    assign w_in_grace = (r_grace != '0);

    always_comb begin
        w_grace_nxt = r_grace;
        if (r_state == c_ST_IDLE && bus.start) begin
            w_grace_nxt = c_GRACE_W'(GRACE_FRAMES);
        end else if (r_state == c_ST_RUN && bus.frame_tick && w_in_grace) begin
            w_grace_nxt = r_grace - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (restart) begin
            r_grace <= '0;
        end else begin
            r_grace <= w_grace_nxt;
        end
    end
`else
    assign w_in_grace = 1'b0;
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_hit_cnt_nxt = r_hit_cnt;
        w_hit_idx_nxt = r_hit_idx;
        case (r_state)
            c_ST_IDLE: begin
                if (bus.start) begin
                    w_state_nxt   = c_ST_RUN;
                    w_hit_cnt_nxt = '0;
                end
            end
            c_ST_RUN: begin
                // Only the overlap sampled on a frame tick advances the filter.
                if (bus.frame_tick) begin
                    if (w_in_grace) begin
                        w_hit_cnt_nxt = '0;
                    end else if (r_hit_any) begin
                        w_hit_cnt_nxt = w_hit_cnt_inc;
                        if (w_hit_cnt_inc == c_HIT_FRAMES) begin
                            w_state_nxt   = c_ST_OVER;
                            w_hit_idx_nxt = w_low_idx;
                        end
                    end else begin
                        w_hit_cnt_nxt = '0;
                    end
                end
            end
            c_ST_OVER: begin
                w_state_nxt = c_ST_OVER;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (restart) begin
            r_state   <= c_ST_IDLE;
            r_hit_cnt <= '0;
            r_hit_idx <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_hit_cnt <= w_hit_cnt_nxt;
            r_hit_idx <= w_hit_idx_nxt;
        end
    end

    assign bus.hit_mask  = r_hit_mask;
    assign bus.hit_any   = r_hit_any;
    assign bus.running   = (r_state == c_ST_RUN);
    assign bus.game_over = (r_state == c_ST_OVER);
    assign bus.hit_idx   = r_hit_idx;

endmodule

`default_nettype wire

// File: tb/tb_collision_monitor.sv
//------------------------------------------------------------------------------
// Module   : tb_collision_monitor
// Brief    : Self-checking bench for collision_monitor (scoreboarded hit_mask).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_collision_monitor;

    localparam int W          = 10;
    localparam int N_OBST     = 4;
    localparam int IDX_W      = 2;
    localparam int HIT_FRAMES = 2;
    localparam int GRACE_TB   = 3;
`ifdef COLLIDE_GRACE_EN
    localparam int GRACE_TICKS = GRACE_TB;
`else
    localparam int GRACE_TICKS = 0;
`endif

    logic clk = 1'b0;
    logic restart;

    always #5 clk = ~clk;

    collision_monitor_if #(.W(W), .N_OBST(N_OBST), .IDX_W(IDX_W)) bus ();

    collision_monitor #(
        .W(W), .N_OBST(N_OBST), .IDX_W(IDX_W),
        .DINO_HW(20), .DINO_HH(25), .OBST_HW(10), .OBST_HH(20),
        .HIT_FRAMES(HIT_FRAMES), .GRACE_FRAMES(GRACE_TB)
    ) dut (
        .clk     (clk),
        .restart (restart),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [N_OBST-1:0] exp_q[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference overlap: half-width sums 30 (x) and 45 (y), strict compare.
    function automatic logic [N_OBST-1:0] model_mask();
        logic [N_OBST-1:0] m;
        m = '0;
        for (int k = 0; k < N_OBST; k++) begin
            int dx;
            int dy;
            dx = int'(bus.dino_x) - int'(bus.obst_x[k*W +: W]);
            dy = int'(bus.dino_y) - int'(bus.obst_y[k*W +: W]);
            if (dx < 0) dx = -dx;
            if (dy < 0) dy = -dy;
            if (bus.obst_valid[k] && dx < 30 && dy < 45) m[k] = 1'b1;
        end
        return restart ? '0 : m;
    endfunction

    task automatic cycle();
        logic [N_OBST-1:0] m;
        exp_q.push_back(model_mask());
        @(posedge clk);
        #1;
        m = exp_q.pop_front();
        check_val("hit_mask", 32'(bus.hit_mask), 32'(m));
        check_val("hit_any", 32'(bus.hit_any), 32'(|m));
    endtask

    task automatic tick();
        bus.frame_tick = 1'b1;
        cycle();
        bus.frame_tick = 1'b0;
    endtask

    task automatic set_obst(input int k, input int x, input int y);
        bus.obst_x[k*W +: W] = W'(x);
        bus.obst_y[k*W +: W] = W'(y);
    endtask

    task automatic park_all();
        for (int k = 0; k < N_OBST; k++) set_obst(k, 900, 100);
    endtask

    task automatic check_ctrl(input string tag, input logic run, input logic over,
                              input logic [IDX_W-1:0] idx);
        check_val({tag, ".running"},   32'(bus.running),   32'(run));
        check_val({tag, ".game_over"}, 32'(bus.game_over), 32'(over));
        check_val({tag, ".hit_idx"},   32'(bus.hit_idx),   32'(idx));
    endtask

    task automatic do_restart(input int n);
        restart = 1'b1;
        for (int i = 0; i < n; i++) cycle();
        restart = 1'b0;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        cycle();
        bus.start = 1'b0;
    endtask

    initial begin
        restart        = 1'b1;
        bus.frame_tick = 1'b0;
        bus.start      = 1'b0;
        bus.dino_x     = W'(250);
        bus.dino_y     = W'(475);
        bus.obst_valid = 4'b0001;
        park_all();

        // Reset, then start a run
        do_restart(2);
        check_ctrl("reset", 1'b0, 1'b0, '0);
        do_start();
        check_ctrl("start", 1'b1, 1'b0, '0);

        // Basic hit persisting two ticks
        set_obst(0, 270, 480);
        cycle();
        tick();
        check_ctrl("tick1", 1'b1, 1'b0, '0);
        tick();
        check_ctrl("tick2_over", 1'b0, 1'b1, '0);

        // Boundary cases, no ticks
        do_restart(1);
        do_start();
        set_obst(0, 280, 475);
        cycle();
        set_obst(0, 250, 520);
        cycle();
        set_obst(0, 250, 519);
        cycle();
        set_obst(0, 220, 430);
        cycle();
        check_ctrl("boundary", 1'b1, 1'b0, '0);

        // Multi-channel with a disabled overlapping channel
        park_all();
        set_obst(1, 260, 470);
        set_obst(2, 250, 475);
        set_obst(3, 240, 480);
        bus.obst_valid = 4'b1010;
        cycle();
        tick();
        tick();
        check_ctrl("multi_over", 1'b0, 1'b1, 2'd1);
        do_start();
        check_ctrl("start_in_over", 1'b0, 1'b1, 2'd1);

        // Restart from OVER clears everything in one cycle
        do_restart(1);
        check_ctrl("restart_over", 1'b0, 1'b0, '0);

        // All channels disabled while overlapping
        do_start();
        set_obst(0, 250, 475);
        set_obst(1, 250, 475);
        bus.obst_valid = 4'b0000;
        cycle();
        tick();
        tick();
        tick();
        check_ctrl("all_disabled", 1'b1, 1'b0, '0);

        // Non-persistent hit: hit, clear, hit
        park_all();
        set_obst(0, 255, 470);
        bus.obst_valid = 4'b0001;
        cycle();
        tick();
        park_all();
        cycle();
        tick();
        set_obst(0, 255, 470);
        cycle();
        tick();
        check_ctrl("nonpersist", 1'b1, 1'b0, '0);
        // Mask changes between ticks are invisible to the filter
        park_all();
        cycle();
        set_obst(0, 255, 470);
        cycle();
        check_ctrl("between_ticks", 1'b1, 1'b0, '0);
        tick();
        check_ctrl("nonpersist_over", 1'b0, 1'b1, '0);

        // Restart and start together: restart wins
        restart   = 1'b1;
        bus.start = 1'b1;
        cycle();
        restart   = 1'b0;
        bus.start = 1'b0;
        check_ctrl("restart_start", 1'b0, 1'b0, '0);

        // Continuous overlap from start: over only after grace + HIT_FRAMES ticks
        do_start();
        for (int t = 1; t <= GRACE_TICKS + HIT_FRAMES; t++) begin
            tick();
            check_val("grace_over_tick", 32'(bus.game_over),
                      32'(t == GRACE_TICKS + HIT_FRAMES));
            cycle();
        end
        check_ctrl("grace_end", 1'b0, 1'b1, '0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/collision_monitor.md
Name: collision_monitor

Overview:
- Parametrised, clocked successor to the single-obstacle dinosaur collision check.
- Tests the dinosaur hitbox against N_OBST obstacle hitboxes using axis-aligned box overlap. Any channel can be individually disabled.
- Requires a collision to persist for HIT_FRAMES frame ticks before declaring game over. Latches game over and the index of the offending obstacle until restart.
- Sits between the object-position logic and the game-control/display logic.

Parameters:
W, 10, coordinate width (unsigned pixels)
N_OBST, 4, number of obstacle channels (1..8)
IDX_W, 2, width of hit_idx; must be >= clog2(N_OBST), minimum 1
DINO_HW, 20, dinosaur half-width in pixels
DINO_HH, 25, dinosaur half-height in pixels
OBST_HW, 10, obstacle half-width in pixels
OBST_HH, 20, obstacle half-height in pixels
HIT_FRAMES, 2, consecutive colliding frame ticks required for game over (>=1)
GRACE_FRAMES, 30, grace length in frame ticks (used only with COLLIDE_GRACE_EN)

Ports:
clk  in  1  system clock
restart  in  1  synchronous active-high reset; also the game restart
frame_tick  in  1  one-cycle pulse per video frame
start  in  1  one-cycle pulse to begin a run
dino_x  in  W  dinosaur centre x
dino_y  in  W  dinosaur centre y
obst_x  in  N_OBST*W  obstacle centre x, channel k at bits [k*W +: W]
obst_y  in  N_OBST*W  obstacle centre y, same packing
obst_valid  in  N_OBST  channel enable; 0 means the channel never hits
hit_mask  out  N_OBST  registered per-channel overlap
hit_any  out  1  registered OR of hit_mask
running  out  1  high in state RUN
game_over  out  1  high in state OVER
hit_idx  out  IDX_W  lowest colliding channel index latched on entry to OVER

Behaviour:
- Reset: clk and restart are the only clock and reset. The reset is synchronous, active-high, and overrides every other input. It sets state=IDLE, hit_mask=0, hit_any=0, hit counter=0, grace counter=0, hit_idx=0, running=0, game_over=0.
- Overlap test for channel k:
  - dx = |dino_x - obst_x[k]| and dy = |dino_y - obst_y[k]|, computed in W+1-bit signed arithmetic with no wrap.
  - Hit when obst_valid[k] AND dx < DINO_HW+OBST_HW AND dy < DINO_HH+OBST_HH.
  - Comparisons are strict. Equality is not a hit.
  - The threshold sums are computed at width W+1.
- Latency: inputs at cycle n produce hit_mask and hit_any at cycle n+1. hit_mask updates every cycle in all states except reset.
- States:
  - IDLE: waits for start=1, then goes to RUN next cycle and clears the hit counter.
  - RUN: running=1. On a cycle where frame_tick=1:
    - If hit_any=1, the hit counter increments.
    - If the incremented value equals HIT_FRAMES, the next state is OVER and hit_idx captures the lowest set bit of the current hit_mask.
    - If hit_any=0, the hit counter clears.
    - Cycles without frame_tick leave the counter unchanged.
  - OVER: game_over=1 and hit_idx is held. start is ignored. The block leaves OVER only through restart.
- start while in RUN: ignored.
- Simultaneous restart and start: restart wins; the state is IDLE.
- Hit counter width: clog2(HIT_FRAMES)+1. The counter saturates and never wraps.
- HIT_FRAMES=1: the first frame_tick with hit_any=1 enters OVER.
- hit_mask changing between frame ticks has no effect on the counter. Only the value sampled on a frame_tick cycle counts.

Optional Feature:
- Macro: COLLIDE_GRACE_EN.
- When defined:
  - Entering RUN loads the grace counter with GRACE_FRAMES.
  - While the grace counter is nonzero, each frame_tick decrements it, and the hit counter is held at 0 regardless of hit_any.
  - Collision counting starts on the first frame_tick after the grace counter reaches 0.
  - hit_mask and hit_any still update normally during grace.
- When not defined: there is no grace counter and counting starts on the first frame_tick in RUN.

Test Plan:
- Reset and start: restart=1 for 2 cycles, then start pulse -> running=1, game_over=0, hit_mask=0.
- Defaults, HIT_FRAMES=2, no macro. dino=(250,475), obst0=(270,480), valid=0001, two frame_ticks -> hit_mask=0001 one cycle after inputs; game_over=1 after the second tick; hit_idx=0.
- Boundary: obst0=(280,475), giving dx=30 -> hit_mask=0. Then obst0=(250,520), giving dy=45 -> hit_mask=0. Then obst0=(250,519) -> hit_mask=0001.
- Multi-channel and disable: obst1 and obst3 overlap, valid=1010 -> hit_mask=1010 and hit_idx=1 on OVER. With valid=0000 -> hit_mask=0 and no game over.
- Non-persistent hit: hit on tick 1, clear on tick 2, hit on tick 3 -> game_over stays 0. Then restart during OVER -> IDLE and all outputs 0 on the next cycle.
- With COLLIDE_GRACE_EN and GRACE_FRAMES=3: continuous overlap from start -> game_over asserts after frame tick 5 (3 grace ticks plus 2 counting ticks), not earlier.
